// File: rtl/dcache_dm.sv
// Direct-mapped, write-back, write-allocate data cache between a byte-wide CPU
// data port and a block-wide data memory, with saturating hit/miss counters.
module dcache_dm #(
  parameter int ADDR_W      = 8,
  parameter int SETS        = 8,
  parameter int BLOCK_BYTES = 4,
  parameter int CNT_W       = 16
) (
  input  logic                                  CLK,
  input  logic                                  RESET,
  input  logic                                  READ,
  input  logic                                  WRITE,
  input  logic [ADDR_W-1:0]                     ADDRESS,
  input  logic [7:0]                            WRITEDATA,
  output logic [7:0]                            READDATA,
  output logic                                  BUSYWAIT,
  output logic                                  MEM_READ,
  output logic                                  MEM_WRITE,
  output logic [ADDR_W-$clog2(BLOCK_BYTES)-1:0] MEM_ADDRESS,
  output logic [8*BLOCK_BYTES-1:0]              MEM_WRITEDATA,
  input  logic [8*BLOCK_BYTES-1:0]              MEM_READDATA,
  input  logic                                  MEM_BUSYWAIT,
  output logic [CNT_W-1:0]                      HIT_COUNT,
  output logic [CNT_W-1:0]                      MISS_COUNT
);

  localparam int OFF_W = $clog2(BLOCK_BYTES);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int BLK_W = 8 * BLOCK_BYTES;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

  state_t           state, state_nxt;
  logic [SETS-1:0]  valid, dirty;
  logic [TAG_W-1:0] tags  [SETS];
  logic [BLK_W-1:0] lines [SETS];

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;
  logic             req, hit, rd_hit, wr_hit, mem_done;
  logic             strobe_seen;
  logic             refilled;
  logic [7:0]       sel_byte, rd_hold;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign off      = ADDRESS[OFF_W-1:0];
  assign idx      = ADDRESS[OFF_W +: IDX_W];
  assign req_tag  = ADDRESS[ADDR_W-1 -: TAG_W];
  assign req      = READ | WRITE;
  assign hit      = valid[idx] && (tags[idx] == req_tag);
  assign sel_byte = lines[idx][{off, 3'b000} +: 8];

  // READ wins when both are asserted; nothing completes while reset is held.
  assign rd_hit   = RESET && (state == IDLE) && READ && hit;
  assign wr_hit   = RESET && (state == IDLE) && WRITE && !READ && hit;
  assign READDATA = rd_hit ? sel_byte : rd_hold;

  // A strobe may only complete once it has been up for a full cycle, giving
  // memory time to raise MEM_BUSYWAIT.
  assign mem_done = strobe_seen && !MEM_BUSYWAIT;

  always_comb begin
    state_nxt     = state;
    BUSYWAIT      = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    case (state)
      IDLE: begin
        BUSYWAIT = req && !hit;
        if (req && !hit)
          state_nxt = (valid[idx] && dirty[idx]) ? WRITEBACK : FETCH;
      end
      WRITEBACK: begin
        BUSYWAIT      = 1'b1;
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {tags[idx], idx};
        MEM_WRITEDATA = lines[idx];
        if (mem_done) state_nxt = FETCH;
      end
      FETCH: begin
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {req_tag, idx};
        if (mem_done) state_nxt = UPDATE;
      end
      UPDATE: begin
        BUSYWAIT  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!RESET) BUSYWAIT = 1'b0;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      strobe_seen <= 1'b0;
      refilled    <= 1'b0;
      valid       <= '0;
      dirty       <= '0;
      rd_hold     <= '0;
      HIT_COUNT   <= '0;
      MISS_COUNT  <= '0;
    end else begin
      state       <= state_nxt;
      strobe_seen <= (state_nxt == state) && ((state == WRITEBACK) || (state == FETCH));
      // The request held through a refill hits next cycle but was already a miss.
      refilled    <= (state == UPDATE);
      if (rd_hit) rd_hold <= sel_byte;
      if ((state == IDLE) && req && hit && !refilled) HIT_COUNT <= sat_inc(HIT_COUNT);
      if ((state == IDLE) && req && !hit) MISS_COUNT <= sat_inc(MISS_COUNT);
      if (state == UPDATE) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end else if (wr_hit) begin
        dirty[idx] <= 1'b1;
      end
    end
  end

  // Line storage carries no reset; valid bits guard its contents.
  always_ff @(posedge CLK) begin
    if (state == UPDATE) begin
      lines[idx] <= MEM_READDATA;
      tags[idx]  <= req_tag;
    end else if (wr_hit) begin
      lines[idx][{off, 3'b000} +: 8] <= WRITEDATA;
    end
  end

endmodule

// File: tb/tb_dcache_dm.sv
// Randomised bench for dcache_dm against an array-level cache/memory model,
// with a second CNT_W=2 instance sharing stimulus to exercise saturation.
module tb_dcache_dm;

  typedef struct packed {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
  } op_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        READ = 1'b0, WRITE = 1'b0;
  logic [7:0]  ADDRESS = '0, WRITEDATA = '0;
  logic [7:0]  READDATA, b_READDATA;
  logic        BUSYWAIT, b_BUSYWAIT;
  logic        MEM_READ, MEM_WRITE, b_MEM_READ, b_MEM_WRITE;
  logic [5:0]  MEM_ADDRESS, b_MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA, b_MEM_WRITEDATA;
  logic [31:0] MEM_READDATA = '0;
  logic        MEM_BUSYWAIT = 1'b0;
  logic [15:0] HIT_COUNT, MISS_COUNT;
  logic [1:0]  b_HIT_COUNT, b_MISS_COUNT;

  dcache_dm #(.ADDR_W(8), .SETS(8), .BLOCK_BYTES(4), .CNT_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
    .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT), .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
  );

  dcache_dm #(.ADDR_W(8), .SETS(8), .BLOCK_BYTES(4), .CNT_W(2)) dut_sat (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
    .WRITEDATA(WRITEDATA), .READDATA(b_READDATA), .BUSYWAIT(b_BUSYWAIT),
    .MEM_READ(b_MEM_READ), .MEM_WRITE(b_MEM_WRITE), .MEM_ADDRESS(b_MEM_ADDRESS),
    .MEM_WRITEDATA(b_MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT), .HIT_COUNT(b_HIT_COUNT), .MISS_COUNT(b_MISS_COUNT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_default(input logic [5:0] a);
    logic [31:0] v;
    v = 32'h9E37_79B9 * ({26'd0, a} + 32'd1);
    return (a == 6'h09) ? 32'hDDCC_BBAA : v;
  endfunction

  // Memory environment: busy for mem_lat cycles per strobe, then performs it once.
  logic [31:0] env_mem [64];
  bit          env_written [64];
  op_t         op_buf [1024];
  int          op_n = 0;
  int          mem_lat = 0;
  int          rem = 0;
  bit          active = 0, act_wr = 0, done = 0;

  always @(negedge CLK) begin
    if (!RESET || (!MEM_READ && !MEM_WRITE)) begin
      active = 0;
      MEM_BUSYWAIT = 1'b0;
    end else begin
      if (!active || (act_wr != MEM_WRITE)) begin
        active = 1; act_wr = MEM_WRITE; rem = mem_lat; done = 0;
      end
      if (rem > 0) begin
        MEM_BUSYWAIT = 1'b1;
        rem--;
      end else begin
        MEM_BUSYWAIT = 1'b0;
        if (!done) begin
          done = 1;
          if (act_wr) begin
            env_mem[MEM_ADDRESS] = MEM_WRITEDATA;
            env_written[MEM_ADDRESS] = 1;
            op_buf[op_n % 1024] = '{1'b1, MEM_ADDRESS, MEM_WRITEDATA};
          end else begin
            MEM_READDATA = env_written[MEM_ADDRESS] ? env_mem[MEM_ADDRESS] : mem_default(MEM_ADDRESS);
            op_buf[op_n % 1024] = '{1'b0, MEM_ADDRESS, MEM_READDATA};
          end
          op_n++;
        end
      end
    end
  end

  // Reference model: cache lines and backing memory as plain arrays.
  bit          m_valid [8];
  bit          m_dirty [8];
  logic [2:0]  m_tag   [8];
  logic [31:0] m_line  [8];
  logic [31:0] ref_mem [64];
  int          hit_n = 0, miss_n = 0;
  logic [7:0]  last_rd = '0;
  int          last_op_base = 0;

  function automatic logic [63:0] sat16(input int n);
    return (n > 65535) ? 64'd65535 : 64'(n);
  endfunction

  function automatic logic [63:0] sat2(input int n);
    return (n > 3) ? 64'd3 : 64'(n);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      m_valid[s] = 0;
      m_dirty[s] = 0;
    end
    hit_n = 0; miss_n = 0; last_rd = '0;
  endtask

  task automatic access(input bit rd, input logic [7:0] a, input logic [7:0] wd,
                        input int lat, output logic [7:0] rdat);
    logic [2:0] t, i;
    logic [1:0] o;
    bit         hit;
    op_t        exp_ops [$];
    int         stall, exp_stall, base;
    logic [7:0] exp_b;
    t = a[7:5]; i = a[4:2]; o = a[1:0];
    hit = m_valid[i] && (m_tag[i] == t);
    if (!hit) begin
      miss_n++;
      if (m_valid[i] && m_dirty[i]) begin
        exp_ops.push_back('{1'b1, {m_tag[i], i}, m_line[i]});
        ref_mem[{m_tag[i], i}] = m_line[i];
      end
      exp_ops.push_back('{1'b0, {t, i}, ref_mem[{t, i}]});
      m_line[i] = ref_mem[{t, i}];
      m_tag[i] = t; m_valid[i] = 1; m_dirty[i] = 0;
    end else begin
      hit_n++;
    end
    // Per strobe: max(lat+1,2) cycles, plus the IDLE miss cycle and UPDATE.
    exp_stall = hit ? 0 : exp_ops.size() * ((lat + 1 < 2) ? 2 : lat + 1) + 2;
    if (rd) begin
      exp_b = m_line[i][o*8 +: 8];
      last_rd = exp_b;
    end else begin
      m_line[i][o*8 +: 8] = wd;
      m_dirty[i] = 1;
      exp_b = last_rd;
    end

    mem_lat = lat;
    base = op_n;
    last_op_base = base;
    @(negedge CLK);
    READ = rd; WRITE = !rd; ADDRESS = a; WRITEDATA = wd;
    #1;
    stall = 0;
    while (BUSYWAIT && stall < 100) begin
      stall++;
      @(negedge CLK);
      #1;
    end
    check_val("stall_cycles", 64'(stall), 64'(exp_stall));
    check_val(rd ? "readdata" : "readdata_hold", READDATA, exp_b);
    check_val("readdata_sat_inst", b_READDATA, exp_b);
    rdat = READDATA;
    @(posedge CLK);
    #1;
    READ = 0; WRITE = 0;
    check_val("hit_count", HIT_COUNT, sat16(hit_n));
    check_val("miss_count", MISS_COUNT, sat16(miss_n));
    check_val("hit_count_sat", b_HIT_COUNT, sat2(hit_n));
    check_val("miss_count_sat", b_MISS_COUNT, sat2(miss_n));
    check_val("mem_op_count", 64'(op_n - base), 64'(exp_ops.size()));
    for (int k = 0; k < exp_ops.size() && base + k < op_n; k++) begin
      check_val("mem_op_kind", op_buf[(base+k) % 1024].wr, exp_ops[k].wr);
      check_val("mem_op_addr", op_buf[(base+k) % 1024].addr, exp_ops[k].addr);
      check_val("mem_op_data", op_buf[(base+k) % 1024].data, exp_ops[k].data);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    for (int a = 0; a < 64; a++) ref_mem[a] = mem_default(6'(a));
    model_reset();

    repeat (2) @(negedge CLK);
    #1;
    check_val("rst_readdata", READDATA, 8'h00);
    check_val("rst_busywait", BUSYWAIT, 1'b0);
    check_val("rst_mem_read", MEM_READ, 1'b0);
    check_val("rst_mem_write", MEM_WRITE, 1'b0);
    check_val("rst_mem_addr", MEM_ADDRESS, 6'h00);
    check_val("rst_mem_wdata", MEM_WRITEDATA, 32'h0);
    check_val("rst_hits", HIT_COUNT, 16'h0);
    check_val("rst_misses", MISS_COUNT, 16'h0);
    @(negedge CLK);
    RESET = 1'b1;

    access(1, 8'h25, 8'h00, 5, r);
    check_val("first_fill_byte", r, 8'hBB);
    check_val("first_fill_addr", op_buf[last_op_base % 1024].addr, 6'h09);
    access(1, 8'h26, 8'h00, 2, r);
    check_val("hit_byte", r, 8'hCC);
    access(0, 8'h24, 8'h5A, 2, r);
    access(1, 8'h24, 8'h00, 2, r);
    check_val("written_byte", r, 8'h5A);
    access(1, 8'h27, 8'h00, 2, r);
    access(1, 8'h25, 8'h00, 2, r);
    check_val("five_hits", HIT_COUNT, 16'd5);
    check_val("hits_saturated", b_HIT_COUNT, 2'd3);

    access(1, 8'h45, 8'h00, 1, r);
    check_val("victim_addr", op_buf[last_op_base % 1024].addr, 6'h09);
    check_val("victim_data", op_buf[last_op_base % 1024].data, 32'hDDCC_BB5A);
    check_val("refill_addr", op_buf[(last_op_base+1) % 1024].addr, 6'h11);
    check_val("two_misses", MISS_COUNT, 16'd2);

    // Abandon a fill part-way through with an asynchronous reset.
    mem_lat = 5;
    @(negedge CLK);
    READ = 1; ADDRESS = 8'h85;
    repeat (3) @(negedge CLK);
    #1;
    check_val("fetch_in_progress", MEM_READ, 1'b1);
    #1 RESET = 1'b0;
    #1;
    check_val("async_mem_read", MEM_READ, 1'b0);
    check_val("async_busywait", BUSYWAIT, 1'b0);
    check_val("async_mem_addr", MEM_ADDRESS, 6'h00);
    check_val("async_readdata", READDATA, 8'h00);
    check_val("async_misses", MISS_COUNT, 16'h0);
    model_reset();
    @(negedge CLK);
    READ = 0;
    @(negedge CLK);
    RESET = 1'b1;
    access(1, 8'h45, 8'h00, 0, r);
    check_val("miss_after_reset", MISS_COUNT, 16'd1);

    for (int n = 0; n < 200; n++) begin
      logic [7:0] a;
      a = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      access(1'($urandom_range(0, 1)), a, 8'($urandom), $urandom_range(0, 4), r);
      if ($urandom_range(0, 3) == 0) @(negedge CLK);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
